// File: rtl/seq_det_pkg.sv
// Shared types and constants for the time-multiplexed 11001 sequence detector.
package seq_det_pkg;

  localparam int STATE_W = 3;
  localparam int PAT_LEN = 5;

  // Detector progress through the 11001 pattern; 0, 6 and 7 are illegal encodings
  typedef enum logic [STATE_W-1:0] {
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } state_t;

endpackage

// File: rtl/seq_det_sched_if.sv
// Serial-channel bundle between the front-ends and seq_det_sched.
// Carries cnt_sel/cnt_val only when SEQ_HITCNT_EN is defined.
interface seq_det_sched_if #(
  parameter int NCH   = 4,
  parameter int CH_W  = $clog2(NCH),
  parameter int CNT_W = 8
);

  logic [NCH-1:0]  bit_vld;
  logic [NCH-1:0]  bit_in;
  logic [NCH-1:0]  bit_rdy;
  logic [NCH-1:0]  ch_clr;
  logic            det_vld;
  logic [CH_W-1:0] det_ch;
`ifdef SEQ_HITCNT_EN
  logic [CH_W-1:0]  cnt_sel;
  logic [CNT_W-1:0] cnt_val;

  modport master (
    output bit_vld, bit_in, ch_clr, cnt_sel,
    input  bit_rdy, det_vld, det_ch, cnt_val
  );

  modport slave (
    input  bit_vld, bit_in, ch_clr, cnt_sel,
    output bit_rdy, det_vld, det_ch, cnt_val
  );
`else
  modport master (
    output bit_vld, bit_in, ch_clr,
    input  bit_rdy, det_vld, det_ch
  );

  modport slave (
    input  bit_vld, bit_in, ch_clr,
    output bit_rdy, det_vld, det_ch
  );
`endif

endinterface

// File: rtl/seq_step_11001.sv
// Combinational next-state/hit function of the overlapping 11001 Mealy detector.
module seq_step_11001
  import seq_det_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               bit_in,
  output logic [STATE_W-1:0] next_state,
  output logic               hit
);

  // Illegal encodings fall back to S1 so a corrupted slot recovers on its next bit
  always_comb begin
    next_state = S1;
    hit        = 1'b0;
    case (state)
      S1: next_state = bit_in ? S2 : S1;
      S2: next_state = bit_in ? S3 : S1;
      S3: next_state = bit_in ? S3 : S4;
      S4: next_state = bit_in ? S2 : S5;
      S5: begin
        next_state = bit_in ? S2 : S1;
        hit        = bit_in;
      end
      default: next_state = S1;
    endcase
  end

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one 11001 detector core across NCH serial channels.
// Optional per-channel saturating hit counters enabled by SEQ_HITCNT_EN.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CH_W  = $clog2(NCH),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_det_sched_if.slave   bus
);

  if (NCH < 2 || NCH > 16 || CNT_W < 1) begin : g_bad_cfg
    $error("seq_det_sched: unsupported NCH/CNT_W");
  end

  logic [STATE_W-1:0] st [NCH];
  logic [CH_W-1:0]    rr_ptr;
  logic [CH_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [STATE_W-1:0] cur_st;
  logic [STATE_W-1:0] nxt_st;
  logic               hit;
  logic               report;

  // First valid channel at or after the pointer wins; nothing is granted while in reset
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!gnt_any && bus.bit_vld[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
    if (rst) gnt_any = 1'b0;
  end

  assign bus.bit_rdy = gnt_any ? (NCH'(1) << gnt_idx) : '0;
  assign cur_st      = st[gnt_idx];
  assign report      = gnt_any & hit & ~bus.ch_clr[gnt_idx];

  seq_step_11001 u_step (
    .state      (cur_st),
    .bit_in     (bus.bit_in[gnt_idx]),
    .next_state (nxt_st),
    .hit        (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) st[i] <= S1;
      rr_ptr      <= '0;
      bus.det_vld <= 1'b0;
      bus.det_ch  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.ch_clr[i])
          st[i] <= S1;
        else if (gnt_any && gnt_idx == CH_W'(i))
          st[i] <= nxt_st;
      end
      if (gnt_any)
        rr_ptr <= (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
      bus.det_vld <= report;
      if (report) bus.det_ch <= gnt_idx;
    end
  end

`ifdef SEQ_HITCNT_EN
  logic [CNT_W-1:0] hit_cnt [NCH];

  // Counters advance on the consuming edge, so a same-cycle read sees the old value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) hit_cnt[i] <= '0;
      bus.cnt_val <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.ch_clr[i])
          hit_cnt[i] <= '0;
        else if (report && gnt_idx == CH_W'(i) && hit_cnt[i] != '1)
          hit_cnt[i] <= hit_cnt[i] + 1'b1;
      end
      bus.cnt_val <= hit_cnt[bus.cnt_sel];
    end
  end
`endif

endmodule
